// File: rtl/neureka_tcdm_load_scheduler_pkg.sv
// ============================================================================
// Module : neureka_tcdm_load_scheduler_pkg
// Brief  : Shared constants and control/status bundles for the TCDM load scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package neureka_tcdm_load_scheduler_pkg;

    localparam int NEUREKA_MEM_BANDWIDTH_EXT = 288;
    localparam int NEUREKA_LD_MAX_OUT        = 4;
    localparam int NEUREKA_LD_OUT_W          = $clog2(NEUREKA_LD_MAX_OUT + 1);

    typedef struct packed {
        logic enable;
        logic rr_mode;
        logic clear;
    } ld_sched_ctrl_t;

    typedef struct packed {
        logic [NEUREKA_LD_OUT_W-1:0] outstanding;
        logic                        busy;
        logic                        err;
    } ld_sched_flags_t;

endpackage

`default_nettype wire

// File: rtl/neureka_tcdm_load_scheduler_arbiter.sv
// ============================================================================
// Module : neureka_ld_sched_arbiter
// Brief  : Combinational fixed-priority / round-robin winner select, registered RR pointer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module neureka_ld_sched_arbiter #(
    parameter  int N_CH = 4,
    localparam int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_rr_mode,
    input  logic [N_CH-1:0] i_eligible,
    input  logic            i_upd,
    input  logic [IW-1:0]   i_upd_idx,
    output logic            o_valid,
    output logic [IW-1:0]   o_idx
);

    logic [IW-1:0] r_ptr;
    logic [IW:0]   w_cand;

    // Candidate order starts at the pointer in RR mode, at 0 in fixed priority.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_cand = (i_rr_mode ? {1'b0, r_ptr} : '0) + (IW+1)'(k);
            if (w_cand >= (IW+1)'(N_CH)) begin
                w_cand = w_cand - (IW+1)'(N_CH);
            end
            if (!o_valid && i_eligible[w_cand[IW-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_clear) begin
            r_ptr <= '0;
        end else if (i_upd && i_rr_mode) begin
            r_ptr <= (i_upd_idx == IW'(N_CH - 1)) ? '0 : i_upd_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/neureka_tcdm_load_scheduler.sv
// ============================================================================
// Module : neureka_tcdm_load_scheduler
// Brief  : N-channel TCDM load scheduler with in-order tag FIFO and per-channel credits.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module neureka_tcdm_load_scheduler
    import neureka_tcdm_load_scheduler_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int DW      = NEUREKA_MEM_BANDWIDTH_EXT,
    parameter  int AW      = 32,
    parameter  int MAX_OUT = NEUREKA_LD_MAX_OUT,
    parameter  int CREDITS = 2,
    localparam int OW      = $clog2(MAX_OUT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               enable_i,
    input  logic               rr_mode_i,
    input  logic [N_CH-1:0]    ch_req_i,
    input  logic [N_CH*AW-1:0] ch_add_i,
    output logic [N_CH-1:0]    ch_gnt_o,
    output logic [N_CH-1:0]    ch_r_valid_o,
    output logic [DW-1:0]      ch_r_data_o,
    input  logic [N_CH-1:0]    ch_credit_ret_i,
    output logic               tcdm_req_o,
    output logic [AW-1:0]      tcdm_add_o,
    output logic               tcdm_wen_o,
    output logic [DW/8-1:0]    tcdm_be_o,
    input  logic               tcdm_gnt_i,
    input  logic               tcdm_r_valid_i,
    input  logic [DW-1:0]      tcdm_r_data_i,
    output logic [OW-1:0]      outstanding_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(CREDITS + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    ld_sched_ctrl_t  w_ctrl;
    logic [0:0]      r_state;
    logic [IW-1:0]   r_lock_idx;
    logic [CW-1:0]   r_credit [N_CH];
    logic [IW-1:0]   r_tag_mem [MAX_OUT];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [OW-1:0]   r_count;
    logic            r_err;
    logic            w_full, w_empty, w_arb_valid, w_req, w_grant, w_rvalid, w_pop;
    logic [IW-1:0]   w_arb_idx, w_sel, w_head;
    logic [N_CH-1:0] w_eligible;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_ctrl  = '{enable: enable_i, rr_mode: rr_mode_i, clear: clear_i};
    assign w_full  = (r_count == OW'(MAX_OUT));
    assign w_empty = (r_count == '0);

    for (genvar c = 0; c < N_CH; c++) begin : g_elig
        assign w_eligible[c] = ch_req_i[c] & (r_credit[c] != '0) & ~w_full & w_ctrl.enable;
    end

    neureka_ld_sched_arbiter #(
        .N_CH (N_CH)
    ) u_arbiter (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_clear    (w_ctrl.clear),
        .i_rr_mode  (w_ctrl.rr_mode),
        .i_eligible (w_eligible),
        .i_upd      (w_grant),
        .i_upd_idx  (w_sel),
        .o_valid    (w_arb_valid),
        .o_idx      (w_arb_idx)
    );

    // A stalled request stays locked to its channel until the TCDM accepts it.
    assign w_sel   = (r_state == ST_LOCKED) ? r_lock_idx : w_arb_idx;
    assign w_req   = rst_ni & ~w_ctrl.clear & ((r_state == ST_LOCKED) | w_arb_valid);
    assign w_grant = w_req & tcdm_gnt_i;

    assign tcdm_req_o = w_req;
    assign tcdm_add_o = w_req ? ch_add_i[int'(w_sel)*AW +: AW] : '0;
    assign tcdm_wen_o = 1'b1;
    assign tcdm_be_o  = '1;

    assign w_head   = r_tag_mem[r_rptr];
    assign w_rvalid = rst_ni & ~w_ctrl.clear & tcdm_r_valid_i;
    assign w_pop    = w_rvalid & ~w_empty;

    always_comb begin
        ch_gnt_o     = '0;
        ch_r_valid_o = '0;
        if (w_grant) ch_gnt_o[w_sel] = 1'b1;
        if (w_pop)   ch_r_valid_o[w_head] = 1'b1;
    end

    assign ch_r_data_o   = w_pop ? tcdm_r_data_i : '0;
    assign outstanding_o = r_count;
    assign busy_o        = (r_count != '0) | w_req;
    assign err_o         = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_lock_idx <= '0;
        end else if (w_ctrl.clear) begin
            r_state    <= ST_IDLE;
            r_lock_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && !tcdm_gnt_i) begin
                        r_state    <= ST_LOCKED;
                        r_lock_idx <= w_arb_idx;
                    end
                end
                ST_LOCKED: begin
                    if (tcdm_gnt_i) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read below the occupancy count.
    always_ff @(posedge clk_i) begin
        if (w_grant) r_tag_mem[r_wptr] <= w_sel;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_ctrl.clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_grant) r_wptr <= f_inc(r_wptr);
            if (w_pop)   r_rptr <= f_inc(r_rptr);
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_rvalid && w_empty) r_err <= 1'b1;
        end
    end

    // Credits are consumed at grant; a same-cycle return cancels out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < N_CH; c++) r_credit[c] <= CW'(CREDITS);
        end else if (w_ctrl.clear) begin
            for (int c = 0; c < N_CH; c++) r_credit[c] <= CW'(CREDITS);
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_gnt_o[c] && !ch_credit_ret_i[c]) begin
                    r_credit[c] <= r_credit[c] - 1'b1;
                end else if (!ch_gnt_o[c] && ch_credit_ret_i[c] && r_credit[c] != CW'(CREDITS)) begin
                    r_credit[c] <= r_credit[c] + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_neureka_tcdm_load_scheduler.sv
// ============================================================================
// Module : tb_neureka_tcdm_load_scheduler
// Brief  : Directed self-checking bench for the TCDM load scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neureka_tcdm_load_scheduler;
    import neureka_tcdm_load_scheduler_pkg::*;

    localparam int DW = NEUREKA_MEM_BANDWIDTH_EXT;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear, enable, rr_mode;
    logic [3:0]    ch_req, ch_gnt, ch_r_valid, credit_ret;
    logic [4*AW-1:0] ch_add;
    logic [DW-1:0] ch_r_data, tcdm_rdata;
    logic          tcdm_req, tcdm_wen, tcdm_gnt, tcdm_rv, busy, err;
    logic [AW-1:0] tcdm_add;
    logic [DW/8-1:0] tcdm_be;
    logic [2:0]    outstanding;

    int n_tests = 0;
    int n_fail  = 0;

    neureka_tcdm_load_scheduler dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .clear_i         (clear),
        .enable_i        (enable),
        .rr_mode_i       (rr_mode),
        .ch_req_i        (ch_req),
        .ch_add_i        (ch_add),
        .ch_gnt_o        (ch_gnt),
        .ch_r_valid_o    (ch_r_valid),
        .ch_r_data_o     (ch_r_data),
        .ch_credit_ret_i (credit_ret),
        .tcdm_req_o      (tcdm_req),
        .tcdm_add_o      (tcdm_add),
        .tcdm_wen_o      (tcdm_wen),
        .tcdm_be_o       (tcdm_be),
        .tcdm_gnt_i      (tcdm_gnt),
        .tcdm_r_valid_i  (tcdm_rv),
        .tcdm_r_data_i   (tcdm_rdata),
        .outstanding_o   (outstanding),
        .busy_o          (busy),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [3:0] oh(input int c);
        return 4'b0001 << c;
    endfunction

    function automatic logic [DW-1:0] pat(input int i);
        return {(DW/32){32'hC0DE0000 + 32'(i)}};
    endfunction

    function automatic logic [AW-1:0] base_add(input int c);
        return 32'h1000 * 32'(c + 1);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; ch_req = '0; credit_ret = '0;
        tcdm_gnt = 1'b0; tcdm_rv = 1'b0; tcdm_rdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; rr_mode = 1'b0;
        idle_inputs();
        for (int c = 0; c < 4; c++) ch_add[c*AW +: AW] = base_add(c);
        ch_req = 4'b1111; tcdm_gnt = 1'b1; tcdm_rv = 1'b1; tcdm_rdata = pat(99);
        #4;
        n_tests++; if (tcdm_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", tcdm_req); end
        n_tests++; if (ch_gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", ch_gnt); end
        n_tests++; if (ch_r_valid !== 4'b0 || ch_r_data !== '0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0000", ch_r_valid); end
        n_tests++; if (outstanding !== 3'd0 || busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %0d/%b/%b want 0/0/0", outstanding, busy, err); end
        n_tests++; if (tcdm_wen !== 1'b1 || tcdm_be !== {(DW/8){1'b1}}) begin n_fail++; $display("FAIL reset_wen_be got %b want 1", tcdm_wen); end
        next_cycle();
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_channel();
        for (int i = 0; i < 4; i++) begin
            ch_req     = (i < 3) ? 4'b0100 : 4'b0000;
            ch_add[2*AW +: AW] = 32'h100 + 32'(i) * 32'h10;
            tcdm_gnt   = 1'b1;
            tcdm_rv    = (i > 0);
            tcdm_rdata = pat(i);
            credit_ret = (i > 0) ? 4'b0100 : 4'b0000;
            #4;
            if (i < 3) begin
                n_tests++; if (ch_gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt[%0d] got %b want 0100", i, ch_gnt); end
                n_tests++; if (tcdm_add !== 32'h100 + 32'(i) * 32'h10) begin n_fail++; $display("FAIL single_add[%0d] got %h want %h", i, tcdm_add, 32'h100 + 32'(i) * 32'h10); end
            end
            if (i > 0) begin
                n_tests++; if (ch_r_valid !== 4'b0100 || ch_r_data !== pat(i)) begin n_fail++; $display("FAIL single_rvalid[%0d] got %b want 0100", i, ch_r_valid); end
            end
            n_tests++; if (outstanding !== ((i == 0) ? 3'd0 : 3'd1)) begin n_fail++; $display("FAIL single_out[%0d] got %0d want %0d", i, outstanding, (i == 0) ? 0 : 1); end
            next_cycle();
        end
        idle_inputs();
        ch_add[2*AW +: AW] = base_add(2);
        #4;
        n_tests++; if (outstanding !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_drain got %0d/%b want 0/0", outstanding, busy); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        int prev;
        prev = 0;
        rr_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ch_req = 4'b1111; tcdm_gnt = 1'b1;
            tcdm_rv = (i > 0); tcdm_rdata = pat(10 + i);
            credit_ret = (i > 0) ? oh(prev) : 4'b0000;
            #4;
            n_tests++; if (ch_gnt !== oh(i % 4)) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b want %b", i, ch_gnt, oh(i % 4)); end
            n_tests++; if (tcdm_add !== base_add(i % 4)) begin n_fail++; $display("FAIL rr_add[%0d] got %h want %h", i, tcdm_add, base_add(i % 4)); end
            if (i > 0) begin
                n_tests++; if (ch_r_valid !== oh(prev) || ch_r_data !== pat(10 + i)) begin n_fail++; $display("FAIL rr_rvalid[%0d] got %b want %b", i, ch_r_valid, oh(prev)); end
            end
            prev = i % 4;
            next_cycle();
        end
        idle_inputs();
        tcdm_rv = 1'b1; credit_ret = oh(prev);
        next_cycle();
        rr_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ch_req = 4'b1111; tcdm_gnt = 1'b1;
            tcdm_rv = (i > 0); credit_ret = (i > 0) ? 4'b0001 : 4'b0000;
            #4;
            n_tests++; if (ch_gnt !== 4'b0001) begin n_fail++; $display("FAIL fixed_gnt[%0d] got %b want 0001", i, ch_gnt); end
            next_cycle();
        end
        idle_inputs();
        tcdm_rv = 1'b1; credit_ret = 4'b0001;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_lock_stall();
        for (int i = 0; i < 4; i++) begin
            ch_req   = (i == 0) ? 4'b0010 : 4'b0011;
            enable   = (i == 0);
            tcdm_gnt = (i == 3);
            #4;
            n_tests++; if (tcdm_req !== 1'b1 || tcdm_add !== base_add(1)) begin n_fail++; $display("FAIL lock_add[%0d] got %b/%h want 1/%h", i, tcdm_req, tcdm_add, base_add(1)); end
            n_tests++; if (ch_gnt !== ((i == 3) ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL lock_gnt[%0d] got %b", i, ch_gnt); end
            next_cycle();
        end
        ch_req = 4'b0001; tcdm_gnt = 1'b1; tcdm_rv = 1'b1; credit_ret = 4'b0010;
        #4;
        n_tests++; if (ch_gnt !== 4'b0000 || tcdm_req !== 1'b0) begin n_fail++; $display("FAIL lock_noenable got %b want 0000", ch_gnt); end
        n_tests++; if (ch_r_valid !== 4'b0010) begin n_fail++; $display("FAIL lock_rvalid got %b want 0010", ch_r_valid); end
        next_cycle();
        enable = 1'b1; tcdm_rv = 1'b0; credit_ret = 4'b0000;
        #4;
        n_tests++; if (ch_gnt !== 4'b0001) begin n_fail++; $display("FAIL lock_enable got %b want 0001", ch_gnt); end
        next_cycle();
        idle_inputs();
        tcdm_rv = 1'b1; credit_ret = 4'b0001;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_outstanding_limit();
        logic [3:0] exp_g [9];
        logic [3:0] exp_v [9];
        logic [2:0] exp_o [9];
        logic       rv    [9];
        exp_g = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
        exp_v = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0001};
        exp_o = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd4, 3'd3};
        rv    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rr_mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ch_req = 4'b1111; tcdm_gnt = 1'b1; tcdm_rv = rv[i];
            #4;
            n_tests++; if (ch_gnt !== exp_g[i] || tcdm_req !== (exp_g[i] != 4'b0)) begin n_fail++; $display("FAIL maxout_gnt[%0d] got %b req %b want %b", i, ch_gnt, tcdm_req, exp_g[i]); end
            n_tests++; if (ch_r_valid !== exp_v[i]) begin n_fail++; $display("FAIL maxout_rvalid[%0d] got %b want %b", i, ch_r_valid, exp_v[i]); end
            n_tests++; if (outstanding !== exp_o[i]) begin n_fail++; $display("FAIL maxout_out[%0d] got %0d want %0d", i, outstanding, exp_o[i]); end
            next_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            tcdm_rv = 1'b1;
            #4;
            if (i == 0) begin
                n_tests++; if (outstanding !== 3'd3) begin n_fail++; $display("FAIL maxout_pushpop got %0d want 3", outstanding); end
            end
            n_tests++; if (ch_r_valid !== oh(i + 1)) begin n_fail++; $display("FAIL maxout_drain[%0d] got %b want %b", i, ch_r_valid, oh(i + 1)); end
            next_cycle();
        end
        idle_inputs();
        credit_ret = 4'b1111;
        #4;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL maxout_empty got %0d want 0", outstanding); end
        next_cycle();
        next_cycle();
        idle_inputs();
        rr_mode = 1'b0;
    endtask

    task automatic test_credits();
        logic [3:0] req   [8];
        logic [3:0] ret   [8];
        logic       rv    [8];
        logic [3:0] exp_g [8];
        logic [3:0] exp_v [8];
        req   = '{4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        ret   = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
        rv    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_g = '{4'b1000, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        exp_v = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000};
        for (int i = 0; i < 8; i++) begin
            ch_req = req[i]; credit_ret = ret[i]; tcdm_rv = rv[i]; tcdm_gnt = 1'b1;
            #4;
            n_tests++; if (ch_gnt !== exp_g[i]) begin n_fail++; $display("FAIL credit_gnt[%0d] got %b want %b", i, ch_gnt, exp_g[i]); end
            n_tests++; if (ch_r_valid !== exp_v[i]) begin n_fail++; $display("FAIL credit_rvalid[%0d] got %b want %b", i, ch_r_valid, exp_v[i]); end
            next_cycle();
        end
        idle_inputs();
        credit_ret = 4'b1000;
        next_cycle();
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_error_clear();
        tcdm_rv = 1'b1;
        #4;
        n_tests++; if (ch_r_valid !== 4'b0000 || err !== 1'b0) begin n_fail++; $display("FAIL err_empty got %b/%b want 0000/0", ch_r_valid, err); end
        next_cycle();
        idle_inputs();
        #4;
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", err); end
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            ch_req = 4'b0001; tcdm_gnt = 1'b1;
            #4;
            n_tests++; if (ch_gnt !== 4'b0001) begin n_fail++; $display("FAIL err_load[%0d] got %b want 0001", i, ch_gnt); end
            next_cycle();
        end
        idle_inputs();
        clear = 1'b1; tcdm_rv = 1'b1; ch_req = 4'b0001; tcdm_gnt = 1'b1;
        #4;
        n_tests++; if (outstanding !== 3'd2 || ch_r_valid !== 4'b0 || tcdm_req !== 1'b0) begin n_fail++; $display("FAIL clear_cycle got out %0d rv %b req %b want 2/0000/0", outstanding, ch_r_valid, tcdm_req); end
        next_cycle();
        idle_inputs();
        tcdm_rv = 1'b1;
        #4;
        n_tests++; if (outstanding !== 3'd0 || err !== 1'b0 || ch_r_valid !== 4'b0) begin n_fail++; $display("FAIL clear_after got out %0d err %b rv %b want 0/0/0000", outstanding, err, ch_r_valid); end
        next_cycle();
        idle_inputs();
        ch_req = 4'b0001; tcdm_gnt = 1'b1;
        #4;
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_reset got %b want 1", err); end
        n_tests++; if (ch_gnt !== 4'b0001) begin n_fail++; $display("FAIL clear_credit got %b want 0001", ch_gnt); end
        next_cycle();
        idle_inputs();
        tcdm_rv = 1'b1; tcdm_rdata = pat(77);
        #4;
        n_tests++; if (ch_r_valid !== 4'b0001 || ch_r_data !== pat(77)) begin n_fail++; $display("FAIL err_resp got %b want 0001", ch_r_valid); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        ch_req = 4'b0100; tcdm_gnt = 1'b0;
        #4;
        n_tests++; if (tcdm_req !== 1'b1 || tcdm_add !== base_add(2)) begin n_fail++; $display("FAIL arst_issue got %b/%h want 1/%h", tcdm_req, tcdm_add, base_add(2)); end
        next_cycle();
        #4;
        n_tests++; if (tcdm_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL arst_locked got %b/%b want 1/1", tcdm_req, busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (tcdm_req !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || outstanding !== 3'd0) begin n_fail++; $display("FAIL arst_now got req %b busy %b err %b out %0d want 0/0/0/0", tcdm_req, busy, err, outstanding); end
        next_cycle();
        ch_req = 4'b0000;
        rst_n = 1'b1;
        #4;
        n_tests++; if (tcdm_req !== 1'b0) begin n_fail++; $display("FAIL arst_release got %b want 0", tcdm_req); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_lock_stall();
        test_outstanding_limit();
        test_credits();
        test_error_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
